add_sequencer: RTL

- Controller and result bank for the shared 256-lane polynomial adder in the Kyber encryption datapath.
- Computes u[i] = x[i] + e_1[i] for i = 0..2, and v = y + e_2 + msg_poly.
- Sequences the operand-mux selector over five passes on one adder, captures each 13-bit-per-lane sum, and reduces it mod q.
- Presents reduced u[0..2] and v with a start/busy/done handshake to the downstream compress stage.

---
 rtl/add_sequencer_pkg.sv | 40 ++++
 rtl/add_sequencer_poly_csub.sv | 21 ++
 rtl/add_sequencer.sv | 86 ++++++++
 3 files changed

// File: rtl/add_sequencer_pkg.sv
// Shared constants, state encoding and operand-mux selector codes for the
// Kyber encryption-add sequencer.
package add_sequencer_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;
  localparam int SUM_W   = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_V0 = 3'd1,
    S_U0 = 3'd2,
    S_U1 = 3'd3,
    S_U2 = 3'd4,
    S_V1 = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam logic [2:0] SEL_Y_E2  = 3'd0;
  localparam logic [2:0] SEL_X0    = 3'd1;
  localparam logic [2:0] SEL_X1    = 3'd2;
  localparam logic [2:0] SEL_X2    = 3'd3;
  localparam logic [2:0] SEL_V_MSG = 3'd4;

  // Operand pair the shared adder must present while in state s.
  function automatic logic [2:0] sel_of(input state_e s);
    logic [2:0] r;
    r = SEL_Y_E2;
    case (s)
      S_U0:    r = SEL_X0;
      S_U1:    r = SEL_X1;
      S_U2:    r = SEL_X2;
      S_V1:    r = SEL_V_MSG;
      default: r = SEL_Y_E2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/add_sequencer_poly_csub.sv
// N independent lanes of a single conditional subtract of Q, truncated to
// the coefficient width.
module poly_csub
  import add_sequencer_pkg::*;
(
  input  logic [KYBER_N*SUM_W-1:0]  sum_i,
  output logic [KYBER_N*COEF_W-1:0] red_o
);

  localparam logic [SUM_W-1:0] Q_S = SUM_W'(KYBER_Q);

  for (genvar j = 0; j < KYBER_N; j++) begin : g_lane
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] diff;
    assign s    = sum_i[j*SUM_W +: SUM_W];
    assign diff = s - Q_S;
    // Out-of-range sums still get only one subtract; the top bit is dropped.
    assign red_o[j*COEF_W +: COEF_W] = (s >= Q_S) ? diff[COEF_W-1:0] : s[COEF_W-1:0];
  end

endmodule

// File: rtl/add_sequencer.sv
// Steps the shared polynomial adder through v_partial, u0..u2 and final v,
// reducing each sum mod q into its result register.
module add_sequencer
  import add_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KYBER_N*SUM_W-1:0]   sum_in,
  output logic [2:0]                 sel,
  output logic [KYBER_N*COEF_W-1:0]  v_fb,
  output logic [KYBER_N*COEF_W-1:0]  u0,
  output logic [KYBER_N*COEF_W-1:0]  u1,
  output logic [KYBER_N*COEF_W-1:0]  u2,
  output logic [KYBER_N*COEF_W-1:0]  v,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = KYBER_N * COEF_W;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [PW-1:0]   v_fb_q, v_fb_d;
  logic [PW-1:0]   u0_q, u0_d;
  logic [PW-1:0]   u1_q, u1_d;
  logic [PW-1:0]   u2_q, u2_d;
  logic [PW-1:0]   v_q, v_d;
  logic [PW-1:0]   red;

  poly_csub u_csub (
    .sum_i (sum_in),
    .red_o (red)
  );

  always_comb begin
    state_d = state_q;
    v_fb_d  = v_fb_q;
    u0_d    = u0_q;
    u1_d    = u1_q;
    u2_d    = u2_q;
    v_d     = v_q;
    case (state_q)
      IDLE: if (start) state_d = S_V0;
      S_V0: begin v_fb_d = red; state_d = S_U0; end
      S_U0: begin u0_d   = red; state_d = S_U1; end
      S_U1: begin u1_d   = red; state_d = S_U2; end
      S_U2: begin u2_d   = red; state_d = S_V1; end
      S_V1: begin v_d    = red; state_d = DONE; end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Selector is registered from the next state so it is stable for the whole state.
    sel_d = sel_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_Y_E2;
      v_fb_q  <= '0;
      u0_q    <= '0;
      u1_q    <= '0;
      u2_q    <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      v_fb_q  <= v_fb_d;
      u0_q    <= u0_d;
      u1_q    <= u1_d;
      u2_q    <= u2_d;
      v_q     <= v_d;
    end
  end

  assign sel  = sel_q;
  assign v_fb = v_fb_q;
  assign u0   = u0_q;
  assign u1   = u1_q;
  assign u2   = u2_q;
  assign v    = v_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
